// File: rtl/logic_unit_pkg.sv
// Shared opcode/state types for the handshaked logic unit.
package logic_unit_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_XOR  = 4'b0010,
    OP_NAND = 4'b0011,
    OP_NOTA = 4'b0100,
    OP_NOR  = 4'b0101,
    OP_XNOR = 4'b0110,
    OP_ANDN = 4'b0111,
    OP_SLL  = 4'b1000,
    OP_SRL  = 4'b1001,
    OP_SRA  = 4'b1010,
    OP_ROL  = 4'b1011
  } op_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

  // opcode[3] set selects the shift/illegal class
  localparam logic OP_SHIFT_MSB = 1'b1;

  // Low two opcode bits pick the shift flavour inside the shift class
  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROL = 2'b11;

endpackage

// File: rtl/logic_unit_comb.sv
// Combinational bitwise ops; flags opcodes 1100-1111 as illegal with a zero result.
module logic_unit_comb
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             err_o
);

  // Bitwise result select; shift opcodes yield zero here and are handled by the top
  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    case (op_t'(op_i))
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NAND: result_o = ~(a_i & b_i);
      OP_NOTA: result_o = ~a_i;
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_XNOR: result_o = ~(a_i ^ b_i);
      OP_ANDN: result_o = a_i & ~b_i;
      OP_SLL, OP_SRL, OP_SRA, OP_ROL: result_o = '0;
      default: begin
        result_o = '0;
        err_o    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/logic_unit.sv
// Handshaked logic unit: one-cycle bitwise ops, iterative one-bit-per-cycle shifts.
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_err
);

  state_t           state_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] work_q;
  logic [1:0]       sop_q;
  logic [WIDTH-1:0] data_q;
  logic             zero_q;
  logic             err_q;

  logic [WIDTH-1:0] comb_res;
  logic             comb_err;
  logic             accept;
  logic             is_shift;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] imm_data;
  logic [WIDTH-1:0] work_d;

  // One-bit shift/rotate step used by every SHIFT cycle
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v, input logic [1:0] k);
    logic [WIDTH-1:0] r;
    case (k)
      SH_SLL:  r = {v[WIDTH-2:0], 1'b0};
      SH_SRL:  r = {1'b0, v[WIDTH-1:1]};
      SH_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = {v[WIDTH-2:0], v[WIDTH-1]};
    endcase
    return r;
  endfunction

  logic_unit_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i      (in_a),
    .b_i      (in_b),
    .op_i     (in_op),
    .result_o (comb_res),
    .err_o    (comb_err)
  );

  // Handshake decode and immediate (single-cycle) result select
  always_comb begin
    in_ready = !rst && ((state_q == EMPTY) || ((state_q == FULL) && out_ready));
    accept   = in_valid && in_ready;
    is_shift = (in_op[3] == OP_SHIFT_MSB) && !in_op[2];
    amt      = in_b[SHW-1:0];
    imm_data = is_shift ? in_a : comb_res;
    work_d   = shift1(work_q, sop_q);
  end

  // FSM, shift counter, working register and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      work_q  <= '0;
      sop_q   <= 2'b00;
      data_q  <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      if (is_shift && (amt != '0)) begin
        state_q <= SHIFT;
        work_q  <= in_a;
        cnt_q   <= amt;
        sop_q   <= in_op[1:0];
      end else begin
        state_q <= FULL;
        data_q  <= imm_data;
        zero_q  <= (imm_data == '0);
        err_q   <= comb_err;
      end
    end else begin
      case (state_q)
        SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            state_q <= FULL;
            data_q  <= work_d;
            zero_q  <= (work_d == '0);
            err_q   <= 1'b0;
          end
        end
        FULL: begin
          if (out_ready) state_q <= EMPTY;
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_zero  = zero_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_logic_unit.sv
// Directed, table-driven bench for logic_unit (WIDTH=16).
module tb_logic_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [3:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_zero;
  logic        out_err;

  int tests = 0;
  int fails = 0;

  logic_unit #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [15:0] exp_data;
    logic        exp_zero;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Offer one op at a negedge, wait for accept, then measure cycles to out_valid
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                      output int lat, output int rdy_low);
    int n;
    n = 0;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    in_op = 4'($urandom_range(0, 15));
    lat = 1;
    rdy_low = 0;
    while (!out_valid && lat < 40) begin
      if (!in_ready) rdy_low++;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) chk("result_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int rdy_low;
    int seen;
    logic [3:0]  bb_op[3];
    logic [15:0] bb_exp[3];

    vecs[0]  = '{16'hF0F0, 16'h0FF0, 4'b0000, 16'h00F0, 1'b0, 1'b0, 1};
    vecs[1]  = '{16'hAAAA, 16'h5555, 4'b0001, 16'hFFFF, 1'b0, 1'b0, 1};
    vecs[2]  = '{16'hAAAA, 16'hFFFF, 4'b0010, 16'h5555, 1'b0, 1'b0, 1};
    vecs[3]  = '{16'hF0F0, 16'h0FF0, 4'b0011, 16'hFF0F, 1'b0, 1'b0, 1};
    vecs[4]  = '{16'hAAAA, 16'hFFFF, 4'b0100, 16'h5555, 1'b0, 1'b0, 1};
    vecs[5]  = '{16'h00FF, 16'hFF00, 4'b0101, 16'h0000, 1'b1, 1'b0, 1};
    vecs[6]  = '{16'hAAAA, 16'hFFFF, 4'b0110, 16'hAAAA, 1'b0, 1'b0, 1};
    vecs[7]  = '{16'hF0F0, 16'h0FF0, 4'b0111, 16'hF000, 1'b0, 1'b0, 1};
    vecs[8]  = '{16'h1234, 16'h0010, 4'b1000, 16'h1234, 1'b0, 1'b0, 1};
    vecs[9]  = '{16'h8001, 16'h0004, 4'b1010, 16'hF800, 1'b0, 1'b0, 5};
    vecs[10] = '{16'h8001, 16'h0001, 4'b1011, 16'h0003, 1'b0, 1'b0, 2};
    vecs[11] = '{16'h0001, 16'h000F, 4'b1000, 16'h8000, 1'b0, 1'b0, 16};
    vecs[12] = '{16'h8000, 16'hFFFF, 4'b1001, 16'h0001, 1'b0, 1'b0, 16};
    vecs[13] = '{16'h0001, 16'h0001, 4'b1001, 16'h0000, 1'b1, 1'b0, 2};
    vecs[14] = '{16'hFFFF, 16'hFFFF, 4'b1101, 16'h0000, 1'b1, 1'b1, 1};
    vecs[15] = '{16'h7FFF, 16'h0003, 4'b1010, 16'h0FFF, 1'b0, 1'b0, 4};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_zero", 32'(out_zero), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Table of single operations with result, flags, latency and input blocking
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].op, lat, rdy_low);
      chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d_zero", i), 32'(out_zero), 32'(vecs[i].exp_zero));
      chk($sformatf("v%0d_err", i), 32'(out_err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_rdy_low", i), 32'(rdy_low), 32'(vecs[i].exp_lat - 1));
    end
    @(negedge clk);
    chk("drained", 32'(out_valid), 32'd0);

    // Back-to-back logic ops, one per cycle with no bubble
    bb_op[0] = 4'b0010; bb_exp[0] = 16'h5555;
    bb_op[1] = 4'b0110; bb_exp[1] = 16'hAAAA;
    bb_op[2] = 4'b0100; bb_exp[2] = 16'h5555;
    in_a = 16'hAAAA; in_b = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        chk($sformatf("b2b%0d_valid", i - 1), 32'(out_valid), 32'd1);
        chk($sformatf("b2b%0d_data", i - 1), 32'(out_data), 32'(bb_exp[i - 1]));
      end
      chk($sformatf("b2b%0d_in_ready", i), 32'(in_ready), 32'd1);
      in_op = bb_op[i]; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b2_valid", 32'(out_valid), 32'd1);
    chk("b2b2_data", 32'(out_data), 32'(bb_exp[2]));
    @(negedge clk);

    // Backpressure holds the result; a pending illegal op waits for the drain
    out_ready = 1'b0;
    send(16'hF0F0, 16'h0FF0, 4'b0000, lat, rdy_low);
    in_a = 16'hFFFF; in_b = 16'h1234; in_op = 4'b1101; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_data", i), 32'(out_data), 32'h00F0);
      chk($sformatf("bp%0d_zero", i), 32'(out_zero), 32'd0);
      chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("ill_valid", 32'(out_valid), 32'd1);
    chk("ill_data", 32'(out_data), 32'h0000);
    chk("ill_zero", 32'(out_zero), 32'd1);
    chk("ill_err", 32'(out_err), 32'd1);
    @(negedge clk);

    // Reset in the middle of a shift discards it
    in_a = 16'h0001; in_b = 16'h0008; in_op = 4'b1000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_shift_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_empty", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid_rst_no_result", 32'(seen), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
